// File: rtl/pipTypes.sv
// Shared pipeline types: EX-stage mul/div op codes and the mul/div sequencer states.
package pipTypes;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_MUL  = 4'd1,
    OP_DIV  = 4'd2,
    OP_MTHI = 4'd3,
    OP_MTLO = 4'd4,
    OP_MFHI = 4'd5,
    OP_MFLO = 4'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_FIXUP
  } md_state_t;

  localparam int MD_ITERATIONS = 32;

  function automatic logic isMuldivOp(input muldiv_op_t op);
    return op inside {OP_MUL, OP_DIV, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO};
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: radix-2 shift-add multiplier and restoring divider sharing
// one {upper, lower} register pair. One step per cycle, DATA_WIDTH steps per op.
module muldiv_core
  import pipTypes::*;
#(
  parameter int DATA_WIDTH = MD_ITERATIONS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic                  i_isDiv,
  input  logic [DATA_WIDTH-1:0] i_opA,
  input  logic [DATA_WIDTH-1:0] i_opB,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_upper,
  output logic [DATA_WIDTH-1:0] o_lower
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic                  r_running;
  logic                  r_isDiv;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_upper;
  logic [DATA_WIDTH-1:0] r_lower;
  logic [DATA_WIDTH-1:0] r_operand;

  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_shift;
  logic [DATA_WIDTH-1:0] w_diff;
  logic                  w_fits;

  // Multiply: upper += multiplicand when the multiplier LSB is set; the carry survives the shift.
  assign w_sum   = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_operand} : '0);
  // Divide: the difference always fits in DATA_WIDTH bits whenever the trial subtract succeeds.
  assign w_shift = {r_upper, r_lower[DATA_WIDTH-1]};
  assign w_fits  = (w_shift >= {1'b0, r_operand});
  assign w_diff  = w_shift[DATA_WIDTH-1:0] - r_operand;

  assign o_done  = r_running & (r_count == CW'(DATA_WIDTH - 1));
  assign o_upper = r_upper;
  assign o_lower = r_lower;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_running <= 1'b0;
      r_isDiv   <= 1'b0;
      r_count   <= '0;
      r_upper   <= '0;
      r_lower   <= '0;
      r_operand <= '0;
    end else if (i_start) begin
      r_running <= 1'b1;
      r_isDiv   <= i_isDiv;
      r_count   <= '0;
      r_upper   <= '0;
      r_lower   <= i_isDiv ? i_opA : i_opB;
      r_operand <= i_isDiv ? i_opB : i_opA;
    end else if (r_running) begin
      if (o_done) r_running <= 1'b0;
      else        r_count   <= r_count + CW'(1);
      if (r_isDiv) begin
        r_upper <= w_fits ? w_diff : w_shift[DATA_WIDTH-1:0];
        r_lower <= {r_lower[DATA_WIDTH-2:0], w_fits};
      end else begin
        r_upper <= w_sum[DATA_WIDTH:1];
        r_lower <= {w_sum[0], r_lower[DATA_WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO owner beside EX: accepts mul/div/move ops, stalls EX while iterating,
// and applies sign fixup to the unsigned core result before writing HI/LO.
module muldiv_unit
  import pipTypes::*;
#(
  parameter int DATA_WIDTH = MD_ITERATIONS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  op_valid,
  input  muldiv_op_t            muldiv_op,
  input  logic                  muldiv_op_u,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  stall,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  md_state_t               r_state;
  logic                    r_isDiv;
  logic                    r_negQ;
  logic                    r_negR;
  logic                    r_div0;
  logic [DATA_WIDTH-1:0]   r_aRaw;
  logic [DATA_WIDTH-1:0]   r_hi;
  logic [DATA_WIDTH-1:0]   r_lo;

  logic                    w_accept;
  logic                    w_start;
  logic                    w_signed;
  logic                    w_coreDone;
  logic [DATA_WIDTH-1:0]   w_magA;
  logic [DATA_WIDTH-1:0]   w_magB;
  logic [DATA_WIDTH-1:0]   w_upper;
  logic [DATA_WIDTH-1:0]   w_lower;
  logic [2*DATA_WIDTH-1:0] w_product;

  assign busy      = (r_state != MD_IDLE);
  assign stall     = op_valid & busy & isMuldivOp(muldiv_op);
  assign w_accept  = op_valid & ~stall;
  assign w_start   = w_accept & ((muldiv_op == OP_MUL) | (muldiv_op == OP_DIV));
  assign w_signed  = ~muldiv_op_u;
  // The core works on magnitudes; signs are restored in MD_FIXUP.
  assign w_magA    = (w_signed & a[DATA_WIDTH-1]) ? -a : a;
  assign w_magB    = (w_signed & b[DATA_WIDTH-1]) ? -b : b;
  assign w_product = {w_upper, w_lower};
  assign hi        = r_hi;
  assign lo        = r_lo;

  muldiv_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .clock   (clock),
    .reset_n (reset_n),
    .i_start (w_start),
    .i_isDiv (muldiv_op == OP_DIV),
    .i_opA   (w_magA),
    .i_opB   (w_magB),
    .o_done  (w_coreDone),
    .o_upper (w_upper),
    .o_lower (w_lower)
  );

  // Sequencer: launches the core, waits for its last step, then commits HI/LO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= MD_IDLE;
      r_isDiv <= 1'b0;
      r_negQ  <= 1'b0;
      r_negR  <= 1'b0;
      r_div0  <= 1'b0;
      r_aRaw  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_start) begin
            r_state <= (muldiv_op == OP_DIV) ? MD_DIV : MD_MUL;
            r_isDiv <= (muldiv_op == OP_DIV);
            r_negQ  <= w_signed & (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]);
            r_negR  <= w_signed & a[DATA_WIDTH-1];
            r_div0  <= (b == '0);
            r_aRaw  <= a;
          end else if (w_accept && muldiv_op == OP_MTHI) begin
            r_hi <= a;
          end else if (w_accept && muldiv_op == OP_MTLO) begin
            r_lo <= a;
          end
        end
        MD_MUL, MD_DIV: begin
          if (w_coreDone) r_state <= MD_FIXUP;
        end
        MD_FIXUP: begin
          r_state <= MD_IDLE;
          if (!r_isDiv) begin
            {r_hi, r_lo} <= r_negQ ? -w_product : w_product;
          end else if (r_div0) begin
            r_hi <= r_aRaw;
            r_lo <= '1;
          end else begin
            r_lo <= r_negQ ? -w_lower : w_lower;
            r_hi <= r_negR ? -w_upper : w_upper;
          end
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases with literal results plus
// randomized back-to-back ops checked every cycle against an arithmetic model.
module tb_muldiv_unit;
  import pipTypes::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic       clock       = 1'b0;
  logic       reset_n     = 1'b0;
  logic       op_valid    = 1'b0;
  muldiv_op_t muldiv_op   = OP_NOP;
  logic       muldiv_op_u = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         stall;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int   checks    = 0;
  int   passes    = 0;
  logic cmpEnable = 1'b0;

  always #5 clock = ~clock;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .op_valid    (op_valid),
    .muldiv_op   (muldiv_op),
    .muldiv_op_u (muldiv_op_u),
    .a           (a),
    .b           (b),
    .stall       (stall),
    .busy        (busy),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
  endtask

  // Architectural result {hi, lo} of a MUL/DIV computed with plain 64-bit arithmetic.
  function automatic logic [2*W-1:0] refResult(input muldiv_op_t op, input logic u,
                                               input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [2*W-1:0] prod;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (op == OP_MUL) begin
      if (u) prod = {32'b0, x} * {32'b0, y};
      else   prod = 64'(sx * sy);
      return prod;
    end
    if (y == 0) return {x, 32'hFFFF_FFFF};
    if (u) return {x % y, x / y};
    q = sx / sy;
    r = sx % sy;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // Model: architectural HI/LO plus the number of busy cycles still to run.
  logic [W-1:0] mHi = '0;
  logic [W-1:0] mLo = '0;
  logic [W-1:0] pHi = '0;
  logic [W-1:0] pLo = '0;
  int           mBusyLeft = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mHi = '0; mLo = '0; mBusyLeft = 0;
    end else if (mBusyLeft > 0) begin
      mBusyLeft--;
      if (mBusyLeft == 0) begin mHi = pHi; mLo = pLo; end
    end else if (op_valid) begin
      case (muldiv_op)
        OP_MUL, OP_DIV: begin
          {pHi, pLo} = refResult(muldiv_op, muldiv_op_u, a, b);
          mBusyLeft  = LAT;
        end
        OP_MTHI: mHi = a;
        OP_MTLO: mLo = a;
        default: ;
      endcase
    end
  end

  always @(negedge clock) begin
    if (cmpEnable && reset_n) begin
      checkOutput("cyc.busy", W'(busy), W'(mBusyLeft > 0));
      checkOutput("cyc.stall", W'(stall),
                  W'(op_valid && mBusyLeft > 0 &&
                     (muldiv_op inside {OP_MUL, OP_DIV, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO})));
      checkOutput("cyc.hi", hi, mHi);
      checkOutput("cyc.lo", lo, mLo);
    end
  end

  // Presents one op and holds it until accepted; returns at posedge+1 of the accept edge.
  task automatic applyStimulus(input muldiv_op_t op, input logic u, input logic [W-1:0] x,
                               input logic [W-1:0] y, output int stalled);
    logic st;
    int   guard = 0;
    stalled     = 0;
    op_valid    = 1'b1;
    muldiv_op   = op;
    muldiv_op_u = u;
    a           = x;
    b           = y;
    forever begin
      @(negedge clock);
      st = stall;
      @(posedge clock);
      #1;
      if (!st) break;
      stalled++;
      guard++;
      if (guard > 200) begin
        $display("[TB] FAIL accept.timeout: still stalled after %0d cycles, required acceptance", guard);
        checks++;
        break;
      end
    end
    op_valid  = 1'b0;
    muldiv_op = OP_NOP;
  endtask

  task automatic waitIdle(output int busyCycles);
    int guard = 0;
    busyCycles = 0;
    @(negedge clock);
    while (busy && guard < 200) begin
      busyCycles++;
      guard++;
      @(negedge clock);
    end
    if (busy) begin
      $display("[TB] FAIL idle.timeout: busy=%0b after %0d cycles, required 0", busy, guard);
      checks++;
    end
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return W'($urandom_range(0, 20));
      default: return W'($urandom());
    endcase
  endfunction

  initial begin
    int sc;
    int bc;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset.hi", hi, '0);
    checkOutput("reset.lo", lo, '0);
    checkOutput("reset.busy", W'(busy), '0);
    checkOutput("reset.stall", W'(stall), '0);
    reset_n   = 1'b1;
    cmpEnable = 1'b1;

    applyStimulus(OP_MFLO, 1'b0, '0, '0, sc);
    checkOutput("mflo.after_reset", lo, '0);

    applyStimulus(OP_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sc);
    waitIdle(bc);
    checkOutput("umul.busy_cycles", W'(bc), W'(33));
    checkOutput("umul.hi", hi, 32'hFFFF_FFFE);
    checkOutput("umul.lo", lo, 32'h0000_0001);
    checkOutput("umul.model_hi", mHi, 32'hFFFF_FFFE);

    applyStimulus(OP_MUL, 1'b0, 32'hFFFF_FFFD, 32'd7, sc);
    waitIdle(bc);
    checkOutput("smul.hi", hi, 32'hFFFF_FFFF);
    checkOutput("smul.lo", lo, 32'hFFFF_FFEB);

    applyStimulus(OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, sc);
    waitIdle(bc);
    checkOutput("sdiv.lo", lo, 32'hFFFF_FFFD);
    checkOutput("sdiv.hi", hi, 32'hFFFF_FFFF);
    checkOutput("sdiv.model_lo", mLo, 32'hFFFF_FFFD);

    applyStimulus(OP_DIV, 1'b1, 32'h0000_1234, 32'd0, sc);
    waitIdle(bc);
    checkOutput("div0.hi", hi, 32'h0000_1234);
    checkOutput("div0.lo", lo, 32'hFFFF_FFFF);

    applyStimulus(OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, sc);
    waitIdle(bc);
    checkOutput("ovf.lo", lo, 32'h8000_0000);
    checkOutput("ovf.hi", hi, 32'h0000_0000);

    // MFHI arrives 5 cycles after the MUL accept and must wait out the remaining 28 busy cycles.
    applyStimulus(OP_MUL, 1'b1, 32'h0001_0000, 32'h0003_0000, sc);
    repeat (5) @(posedge clock);
    #1;
    applyStimulus(OP_MFHI, 1'b0, '0, '0, sc);
    checkOutput("mfhi.stall_cycles", W'(sc), W'(28));
    checkOutput("mfhi.hi", hi, 32'h0000_0003);
    checkOutput("mfhi.busy", W'(busy), '0);

    applyStimulus(OP_MTLO, 1'b0, 32'hCAFE_F00D, '0, sc);
    checkOutput("mtlo.stall_cycles", W'(sc), '0);
    checkOutput("mtlo.lo", lo, 32'hCAFE_F00D);
    applyStimulus(OP_MTHI, 1'b0, 32'h1357_9BDF, '0, sc);
    applyStimulus(OP_MFHI, 1'b0, '0, '0, sc);
    checkOutput("mthi_mfhi.hi", hi, 32'h1357_9BDF);

    applyStimulus(OP_DIV, 1'b1, 32'd1000, 32'd7, sc);
    repeat (10) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset.busy", W'(busy), '0);
    checkOutput("midreset.hi", hi, '0);
    checkOutput("midreset.lo", lo, '0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    applyStimulus(OP_MUL, 1'b0, 32'd6, 32'd7, sc);
    waitIdle(bc);
    checkOutput("post_reset_mul.lo", lo, 32'd42);
    checkOutput("post_reset_mul.hi", hi, '0);

    for (int i = 0; i < 150; i++) begin
      applyStimulus(muldiv_op_t'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), pick(), pick(), sc);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end
    end
    waitIdle(bc);
    cmpEnable = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
